// File: rtl/ring_trng_hexdisplay_pkg.sv
// Shared constants and helpers for the ring TRNG with hex readout.
// Holds the default ring length, the LFSR seed and tap positions,
// the 7-segment code table (bit0 = a .. bit6 = g), and small helper functions.
package ring_trng_hexdisplay_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam int          RING_STAGES_DEF = 5;
  localparam logic [15:0] LFSR_SEED_DEF   = 16'hACE1;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register.
  localparam int TAP_0 = 0;
  localparam int TAP_1 = 2;
  localparam int TAP_2 = 3;
  localparam int TAP_3 = 5;

  // Index 15 is the leftmost entry, so the list reads F down to 0.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t hex7(input nibble_t nib);
    return SEG_CODES[nib];
  endfunction

  function automatic logic lfsr_fb(input logic [15:0] s);
    return s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
  endfunction

endpackage

// File: rtl/ring_trng_hexdisplay_lfsr16.sv
// 16-bit Fibonacci LFSR used to whiten the debiased ring stream.
// Ports: clk, rst_n (async active-low, loads seed), seed (nonzero reset
// value), bit_out (current LSB of the state, one new bit per clock).
module lfsr16
  import ring_trng_hexdisplay_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic        bit_out
);

  logic [15:0] state_r;

  // Shift right every clock, feedback enters at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= seed;
    end else begin
      state_r <= {lfsr_fb(state_r), state_r[15:1]};
    end
  end

  assign bit_out = state_r[0];

endmodule

// File: rtl/ring_trng_hexdisplay.sv
// Toy TRNG: clocked inverter-ring model -> XOR debias flop -> XOR with LFSR
// stream -> 4-bit shift window. A synchronised rising edge on sample latches
// the window as the key, shown in hex on one of two 7-segment digits.
// Ports: clk, rst_n (async active-low), startring (1 = ring runs),
// pulse (1 = blank display), sample (async capture strobe),
// diplaychoose (0 = digit A, 1 = digit B),
// displaypin[13:0] ([6:0] digit A a..g, [13:7] digit B a..g, active-high).
module ring_trng_hexdisplay
  import ring_trng_hexdisplay_pkg::*;
#(
  parameter int          RING_STAGES = RING_STAGES_DEF,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        startring,
  input  logic        pulse,
  input  logic        sample,
  input  logic        diplaychoose,
  output logic [13:0] displaypin
);

  logic [RING_STAGES-1:0] ring_r;
  logic                   ring_out_s;
  logic                   debias_r;
  logic                   lfsr_bit_s;
  logic                   mix_s;
  logic [3:0]             win_r;
  logic                   sync1_r;
  logic                   sync2_r;
  logic                   sync3_r;
  logic                   edge_s;
  logic [3:0]             key_r;
  logic [6:0]             seg_s;

  // Johnson-counter ring model: output is low for N clocks, then high for N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_r <= {RING_STAGES{1'b0}};
    end else if (startring) begin
      ring_r <= {ring_r[RING_STAGES-2:0], ~ring_r[RING_STAGES-1]};
    end else begin
      ring_r <= ring_r;
    end
  end

  assign ring_out_s = ring_r[RING_STAGES-1];

  // Debias flop accumulates the ring output by XOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debias_r <= 1'b0;
    end else begin
      debias_r <= debias_r ^ ring_out_s;
    end
  end

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .seed    (LFSR_SEED),
    .bit_out (lfsr_bit_s)
  );

  assign mix_s = lfsr_bit_s ^ debias_r;

  // Shift window collects the most recent four mixed bits, newest in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r <= 4'h0;
    end else begin
      win_r <= {win_r[2:0], mix_s};
    end
  end

  // Two-flop synchroniser for the asynchronous strobe plus one delay for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= sample;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign edge_s = sync2_r & ~sync3_r;

  // Key takes the window value present before the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r <= 4'h0;
    end else if (edge_s) begin
      key_r <= win_r;
    end else begin
      key_r <= key_r;
    end
  end

  // Display decode and digit routing; blanking overrides everything.
  always_comb begin
    seg_s      = hex7(key_r);
    displaypin = 14'h0000;
    if (pulse) begin
      displaypin = 14'h0000;
    end else if (diplaychoose) begin
      displaypin = {seg_s, 7'h00};
    end else begin
      displaypin = {7'h00, seg_s};
    end
  end

endmodule

// File: tb/tb_ring_trng_hexdisplay.sv
module tb_ring_trng_hexdisplay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        startring;
  logic        pulse;
  logic        sample;
  logic        diplaychoose;
  logic [13:0] displaypin;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  ring_trng_hexdisplay dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .startring    (startring),
    .pulse        (pulse),
    .sample       (sample),
    .diplaychoose (diplaychoose),
    .displaypin   (displaypin)
  );

  always #5 clk = ~clk;

  // Reference model: ring output derived from a count of enabled clocks,
  // window and key as plain integers, sample history as a queue.
  int          ring_cnt;
  bit          m_p;
  logic [15:0] m_lfsr;
  int          m_win;
  int          m_key;
  bit          hist[$];

  task automatic model_reset();
    ring_cnt = 0;
    m_p      = 1'b0;
    m_lfsr   = 16'hACE1;
    m_win    = 0;
    m_key    = 0;
    hist     = '{1'b0, 1'b0, 1'b0};
  endtask

  task automatic model_step();
    bit ro;
    bit mx;
    bit fb;
    ro = (ring_cnt >= 5);
    mx = m_lfsr[0] ^ m_p;
    // a rise seen two and three clocks back marks the capture clock
    if (hist[1] && !hist[2]) m_key = m_win;
    m_win = (m_win * 2 + int'(mx)) % 16;
    m_p   = m_p ^ ro;
    fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
    m_lfsr = {fb, m_lfsr[15:1]};
    if (startring) ring_cnt = (ring_cnt + 1) % 10;
    hist.push_front(sample);
    void'(hist.pop_back());
  endtask

  function automatic logic [13:0] ref_disp();
    logic [6:0] seg;
    seg = HEX[m_key];
    if (pulse) return 14'h0000;
    if (diplaychoose) return {seg, 7'h00};
    return {7'h00, seg};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #2;
  endtask

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Enters with rst_n low; releases reset and captures the key that the
  // seed produces with the ring stopped (window 4'b1000 -> digit 8).
  task automatic capture8(input string tg);
    startring    = 1'b0;
    sample       = 1'b0;
    pulse        = 1'b0;
    diplaychoose = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    sample = 1'b1;
    tick();
    check({tg, "_c3"}, displaypin, 14'h003F);
    tick();
    check({tg, "_c4"}, displaypin, 14'h003F);
    tick();
    check({tg, "_key8"}, displaypin, 14'h007F);
  endtask

  initial begin
    rst_n        = 1'b0;
    startring    = 1'b0;
    pulse        = 1'b0;
    sample       = 1'b0;
    diplaychoose = 1'b0;
    model_reset();

    // Reset display values
    #1;
    check("rst_digit_a", displaypin, 14'h003F);
    diplaychoose = 1'b1;
    #1;
    check("rst_digit_b", displaypin, 14'h1F80);
    pulse = 1'b1;
    #1;
    check("rst_blank", displaypin, 14'h0000);
    pulse        = 1'b0;
    diplaychoose = 1'b0;
    tick();
    tick();

    // LFSR-only stream and key capture
    capture8("cap");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cap_hold", displaypin, 14'h007F);
    end
    diplaychoose = 1'b1;
    #1;
    check("cap_digit_b", displaypin, 14'h3F80);
    diplaychoose = 1'b0;
    sample = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cap_fall", displaypin, 14'h007F);
    end

    // Ring running, then frozen; captures every four clocks
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    startring = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sample = ((i % 4) < 2);
      if (i == 50) startring = 1'b0;
      tick();
      check("ring", displaypin, ref_disp());
    end

    // Asynchronous reset mid-cycle after a known capture, then LFSR restart
    rst_n = 1'b0;
    capture8("pre_rst");
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst", displaypin, 14'h003F);
    capture8("restart");

    // Randomised run against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 2) == 0) sample = ~sample;
      if ($urandom_range(0, 15) == 0) startring = ~startring;
      pulse        = ($urandom_range(0, 7) == 0);
      diplaychoose = $urandom_range(0, 1) != 0;
      #1;
      check("rand", displaypin, ref_disp());
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
